disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan controller for the 4-digit multiplexed 7-segment display. It consumes the one-cycle scan tick produced by the display clock divider and sequences digit enables with a dead-time blanking interval between digits. It holds a double-buffered hex digit store, so the authentication FSM can write new values without tearing. Its outputs drive the display pins directly.

## Interface
Parameters:
- DEAD_CYC, 4, number of clk cycles in the blanking interval between digits; legal range 1..255.
- LZ_BLANK, 1, 1 = suppress leading zeros on digits 3..1; 0 = show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 forces outputs dark
- scan_tick  in  1  one-cycle pulse from the display divider; advances to the next digit
- wr_en  in  1  write strobe into the shadow buffer
- wr_addr  in  2  digit index, 0 = least significant / rightmost
- wr_data  in  4  hex nibble
- commit  in  1  request to copy shadow → active at the next frame boundary
- commit_pending  out  1  commit accepted but not yet applied
- an  out  4  one-hot digit enable, active-high, bit i = digit i
- seg  out  7  segments, active-high, bit0=a … bit6=g
- frame_done  out  1  one-cycle pulse after digit 3 completes

## Operation
- Reset (rst=1 at an edge, dominates all inputs): state OFF, idx=0, dead counter=0, shadow and active buffers all 0. Outputs: an=0, seg=0, frame_done=0, commit_pending=0.
- States:
  - OFF: an=0, seg=0. If en=1, go to DEAD with idx=0.
  - DEAD: an=0, seg=0. Lasts exactly DEAD_CYC cycles, then go to DRIVE. scan_tick is ignored in this state.
  - DRIVE: an=onehot(idx), seg=decode(active[idx]), or 0 if the digit is blanked. Hold until scan_tick. On scan_tick: idx←(idx+1) mod 4, go to DEAD.
- en=0 in any state: go to OFF at the next edge and set idx to 0. The dead count is discarded.
- Frame boundary: an edge that samples scan_tick=1 in DRIVE with idx=3.
  - At that edge: frame_done=1 for one cycle.
  - If commit_pending=1 or commit=1: active←shadow and commit_pending←0.
- Commit acceptance:
  - commit=1 outside a boundary edge, with state ≠ OFF: set commit_pending=1.
  - commit while already pending: merged, no further effect.
  - In OFF: commit is applied at that edge; commit_pending stays 0.
  - A pending commit at the en=0 transition is applied on entry to OFF.
- Writes: shadow[wr_addr]←wr_data on any edge with wr_en=1, in all states. Writes never touch active directly.
  - A write coinciding with the commit copy edge is included in the copy: bypass, new value lands in active.
- Hex decode (seg[6:0]): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Leading-zero blanking (LZ_BLANK=1): digit i (i≥1) is blanked when active[j]=0 for all j≥i.
  - For a blanked digit, an is still asserted and seg=0.
  - Digit 0 is never blanked.

## Timing
- an, seg and frame_done are registered, with no combinational path from inputs.
- en rise sampled at edge k:
  - DEAD covers cycles after edges k+1..k+DEAD_CYC.
  - an=0001 with digit-0 seg from edge k+DEAD_CYC+1.
- scan_tick sampled in DRIVE at edge t:
  - an=0 from edge t+1.
  - Next digit driven from edge t+1+DEAD_CYC.
- Digits are never overlapped: at least DEAD_CYC dark cycles separate any two enables.
- Commit latency: applied at the first frame boundary after acceptance. The first digit 0 after frame_done shows the new data.
- commit and the boundary in the same cycle: applied at that edge; commit_pending never rises.
- scan_tick with en=0, or during DEAD: no effect, no idx advance.
- rst mid-frame: next cycle matches the post-reset state exactly.

## Test plan
- Reset/enable, DEAD_CYC=4: rst, then en=1 at edge k → an=0 through edge k+4; an=0001, seg=3F at edge k+5.
- Full scan: shadow={3:A,2:0,1:7,0:5}, commit while OFF, en=1, four scan_ticks → an sequence 0001/0010/0100/1000. seg sequence 6D, 07, 3F, 77. Dead gap between each digit. One frame_done after the 4th tick.
- Tear-free commit: mid-frame, write digit 0=8 and assert commit → commit_pending=1 and the current frame unchanged. frame_done cycle clears pending. Next digit 0 shows seg=7F.
- Commit at boundary edge plus same-cycle write to digit 1=F → commit_pending stays 0. Digit 1 of the next frame shows 71.
- Leading-zero blanking: active={0,0,0,4}, LZ_BLANK=1 → digits 3..1 have an asserted with seg=00; digit 0 seg=66. With all zeros, digit 0 shows 3F.
- Disturbances: scan_tick during DEAD is ignored. en=0 in DRIVE gives an=0 next cycle and idx restarts at 0. rst asserted mid-DRIVE clears buffers, outputs and commit_pending in one cycle.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Sequences digits with dead-time blanking; double-buffered digit store for tear-free updates.
module disp_scan_ctrl #(
    parameter int DEAD_CYC = 4,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scan_tick,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    output logic       commit_pending,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_DEAD,
        S_DRIVE
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [7:0]       dead_cnt;
    logic [3:0][3:0]  shadow;
    logic [3:0][3:0]  active;
    logic [3:0][3:0]  shadow_nxt;
    logic [3:0]       zero_from;
    logic [3:0]       blank;
    logic             drive_out;
    logic             boundary;
    logic             commit_req;
    logic             apply;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // zero_from[i]: every active digit at position i and above is zero
    always_comb begin
        zero_from    = '0;
        zero_from[3] = (active[3] == 4'h0);
        for (int i = 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (active[i] == 4'h0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_blank
            if (g == 0) begin : g_lsd
                assign blank[g] = 1'b0;
            end else begin : g_msd
                assign blank[g] = LZ_BLANK && zero_from[g];
            end
        end
    endgenerate

    // Shadow with the current write folded in, so a write on the copy edge lands in active
    always_comb begin
        shadow_nxt = shadow;
        if (wr_en) begin
            shadow_nxt[wr_addr] = wr_data;
        end
    end

    assign drive_out  = en && (state == S_DRIVE);
    assign boundary   = drive_out && scan_tick && (idx == 2'd3);
    assign commit_req = commit || commit_pending;
    // Copy at a frame boundary, immediately while dark, or when leaving to OFF
    assign apply = ((state == S_OFF) && commit) ||
                   (en ? (boundary && commit_req)
                       : ((state != S_OFF) && commit_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_OFF;
            idx            <= 2'd0;
            dead_cnt       <= 8'd0;
            shadow         <= '0;
            active         <= '0;
            commit_pending <= 1'b0;
            an             <= 4'b0000;
            seg            <= 7'h00;
            frame_done     <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (apply) begin
                active <= shadow_nxt;
            end

            if (apply) begin
                commit_pending <= 1'b0;
            end else if (commit && (state != S_OFF)) begin
                commit_pending <= 1'b1;
            end

            an         <= drive_out ? (4'b0001 << idx) : 4'b0000;
            seg        <= (drive_out && !blank[idx]) ? hex7(active[idx]) : 7'h00;
            frame_done <= boundary;

            if (!en) begin
                state    <= S_OFF;
                idx      <= 2'd0;
                dead_cnt <= 8'd0;
            end else begin
                case (state)
                    S_OFF: begin
                        state    <= S_DEAD;
                        idx      <= 2'd0;
                        dead_cnt <= 8'd0;
                    end
                    S_DEAD: begin
                        if (dead_cnt == DEAD_LAST) begin
                            state    <= S_DRIVE;
                            dead_cnt <= 8'd0;
                        end else begin
                            dead_cnt <= dead_cnt + 8'd1;
                        end
                    end
                    S_DRIVE: begin
                        if (scan_tick) begin
                            idx   <= idx + 2'd1;
                            state <= S_DEAD;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares the registered outputs.
module tb_disp_scan_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       scan_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'h0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.DEAD_CYC(D), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .scan_tick(scan_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .commit_pending(commit_pending), .an(an), .seg(seg), .frame_done(frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: pins lit only while enabled and the dead gap has elapsed
    bit       m_on;
    int       m_gap;
    int       m_d;
    bit [3:0] m_sh[4];
    bit [3:0] m_act[4];
    bit       m_pend;
    bit [6:0] hex_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic bit blanked(int i);
        if (i == 0) return 1'b0;
        for (int j = i; j < 4; j++) if (m_act[j] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string name, logic [6:0] got, logic [6:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("an", 7'(an), 7'(x.an));
            chk("seg", seg, x.seg);
            chk("frame_done", 7'(frame_done), 7'(x.fd));
            chk("commit_pending", 7'(commit_pending), 7'(x.pend));
        end
    end

    task automatic step(bit r, bit e, bit t, bit w, bit [1:0] a, bit [3:0] dat, bit c);
        exp_t x;
        bit lit, bnd, app;
        @(negedge clk);
        #1;
        rst = r; en = e; scan_tick = t; wr_en = w; wr_addr = a; wr_data = dat; commit = c;
        if (r) begin
            m_on = 0; m_gap = 0; m_d = 0; m_pend = 0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            x.an = 0; x.seg = 0; x.fd = 0;
        end else begin
            lit   = e && m_on && (m_gap == 0);
            bnd   = lit && t && (m_d == 3);
            x.an  = lit ? 4'(1 << m_d) : 4'h0;
            x.seg = (lit && !blanked(m_d)) ? hex_tab[m_act[m_d]] : 7'h00;
            x.fd  = bnd;
            app   = (bnd && (m_pend || c)) || (!m_on && c) || (!e && m_on && (m_pend || c));
            if (w) m_sh[a] = dat;
            if (app) m_act = m_sh;
            if (app) m_pend = 0;
            else if (c && m_on) m_pend = 1;
            if (!e) begin
                m_on = 0; m_d = 0; m_gap = 0;
            end else if (!m_on) begin
                m_on = 1; m_d = 0; m_gap = D;
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (t) begin
                m_d = (m_d + 1) % 4; m_gap = D;
            end
        end
        x.pend = m_pend;
        sbq.push_back(x);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_drive();
        for (int n = 0; n < 40 && !(m_on && m_gap == 0); n++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_digit();
        wait_drive();
        step(0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic advance_to(int d);
        for (int n = 0; n < 8 && m_d != d; n++) tick_digit();
        wait_drive();
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Load 3:A 2:0 1:7 0:5 while dark, commit applies immediately
        step(0, 0, 0, 1, 3, 4'hA, 0);
        step(0, 0, 0, 1, 2, 4'h0, 0);
        step(0, 0, 0, 1, 1, 4'h7, 0);
        step(0, 0, 0, 1, 0, 4'h5, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(8);
        for (int i = 0; i < 4; i++) begin tick_digit(); idle(2); end
        // Tear-free commit mid-frame
        advance_to(2);
        step(0, 1, 0, 1, 0, 4'h8, 1);
        idle(2);
        advance_to(0);
        idle(2);
        // Commit with same-cycle write exactly on the boundary edge
        advance_to(3);
        step(0, 1, 1, 1, 1, 4'hF, 1);
        for (int i = 0; i < 4; i++) tick_digit();
        // Leading-zero blanking, then all zeros
        step(0, 1, 0, 1, 3, 4'h0, 0);
        step(0, 1, 0, 1, 2, 4'h0, 0);
        step(0, 1, 0, 1, 1, 4'h0, 0);
        step(0, 1, 0, 1, 0, 4'h4, 1);
        for (int i = 0; i < 8; i++) tick_digit();
        step(0, 1, 0, 1, 0, 4'h0, 1);
        for (int i = 0; i < 8; i++) tick_digit();
        // Ticks during dead time are ignored
        tick_digit();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
        // en drop mid-drive with a pending commit
        step(0, 1, 0, 1, 2, 4'h3, 1);
        wait_drive();
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(7);
        // rst mid-drive with a pending commit
        step(0, 1, 0, 0, 0, 0, 1);
        wait_drive();
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 4'h9, 1);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 11) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL drain: got %0d left want 0", sbq.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
